// File: rtl/mips_alu_pkg.sv
// Shared opcode, state and helper definitions for the sequential MIPS ALU.
// Optional divider is selected by the MIPS_ALU_SEQ_DIV_EN macro.
package mips_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_MULTU = 4'b0100,
        OP_DIVU  = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_SLL   = 4'b1000,
        OP_SRL   = 4'b1001,
        OP_SRA   = 4'b1010,
        OP_SLTU  = 4'b1011,
        OP_NOR   = 4'b1100,
        OP_MFHI  = 4'b1101,
        OP_MFLO  = 4'b1110
    } alu_op_e;

`ifdef MIPS_ALU_SEQ_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
`else
    typedef enum logic [1:0] {IDLE, MUL} state_e;
`endif

    function automatic logic is_multicycle(input alu_op_e op);
`ifdef MIPS_ALU_SEQ_DIV_EN
        return (op == OP_MULTU) || (op == OP_DIVU);
`else
        return op == OP_MULTU;
`endif
    endfunction

endpackage

// File: rtl/mips_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Divider datapath exists only when MIPS_ALU_SEQ_DIV_EN is defined.
module mips_alu_muldiv
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef MIPS_ALU_SEQ_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] m_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   mul_sum;

    // hi/lo present the value after the current step; done marks the last step
    assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : '0);
    assign done    = busy && (cnt == CNT_W'(WIDTH - 1));

`ifdef MIPS_ALU_SEQ_DIV_EN
    logic             div_r;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign div_sh   = {hi_r, lo_r[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, m_r};
    assign div_diff = div_sh[WIDTH-1:0] - m_r;
    assign hi = div_r ? (div_ge ? div_diff : div_sh[WIDTH-1:0])
                      : mul_sum[WIDTH:1];
    assign lo = div_r ? {lo_r[WIDTH-2:0], div_ge}
                      : {mul_sum[0], lo_r[WIDTH-1:1]};
`else
    assign hi = mul_sum[WIDTH:1];
    assign lo = {mul_sum[0], lo_r[WIDTH-1:1]};
`endif

    // load operands on start, then advance one bit per cycle until done
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            hi_r <= '0;
            lo_r <= '0;
            m_r  <= '0;
`ifdef MIPS_ALU_SEQ_DIV_EN
            div_r <= 1'b0;
`endif
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            hi_r <= '0;
`ifdef MIPS_ALU_SEQ_DIV_EN
            div_r <= div_mode;
            lo_r  <= div_mode ? a : b;
            m_r   <= div_mode ? b : a;
`else
            lo_r <= b;
            m_r  <= a;
`endif
        end else if (busy) begin
            hi_r <= hi;
            lo_r <= lo;
            cnt  <= cnt + CNT_W'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_alu_seq.sv
// Registered MIPS ALU with valid/ready handshake and HI/LO for MULTU/DIVU.
// Define MIPS_ALU_SEQ_DIV_EN to build the DIVU datapath.
module mips_alu_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    state_e           state;
    alu_op_e          op;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             accept;
    logic             start;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             ill;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHAMT_W-1:0] shamt;
    logic             eng_busy;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    assign op       = alu_op_e'(ALUControl);
    assign in_ready = (state == IDLE) && !eng_busy && !reset
                      && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign start    = accept && is_multicycle(op);
    assign sum      = A + B;
    assign diff     = A - B;
    assign shamt    = B[SHAMT_W-1:0];

    mips_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (SHAMT_W)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef MIPS_ALU_SEQ_DIV_EN
        .div_mode (op == OP_DIVU),
`endif
        .a        (A),
        .b        (B),
        .busy     (eng_busy),
        .done     (eng_done),
        .hi       (eng_hi),
        .lo       (eng_lo)
    );

    // single-cycle result, overflow and illegal-opcode decode
    always_comb begin
        res = '0;
        ovf = 1'b0;
        ill = 1'b0;
        case (op)
            OP_AND:   res = A & B;
            OP_OR:    res = A | B;
            OP_XOR:   res = A ^ B;
            OP_NOR:   res = ~(A | B);
            OP_ADD: begin
                res = sum;
                ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, A < B};
            OP_SLL:   res = A << shamt;
            OP_SRL:   res = A >> shamt;
            OP_SRA:   res = $signed(A) >>> shamt;
            OP_MFHI:  res = hi_q;
            OP_MFLO:  res = lo_q;
            OP_MULTU: res = '0;
`ifdef MIPS_ALU_SEQ_DIV_EN
            OP_DIVU:  res = '0;
`endif
            default:  ill = 1'b1;
        endcase
    end

    // handshake FSM, output register and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MULTU) begin
                            state <= MUL;
`ifdef MIPS_ALU_SEQ_DIV_EN
                        end else if (op == OP_DIVU) begin
                            state <= DIV;
`endif
                        end else begin
                            out_valid <= 1'b1;
                            ALUResult <= res;
                            Zero      <= (res == '0);
                            Overflow  <= ovf;
                            Illegal   <= ill;
                        end
                    end
                end
                default: begin
                    if (eng_done) begin
                        state     <= IDLE;
                        hi_q      <= eng_hi;
                        lo_q      <= eng_lo;
                        out_valid <= 1'b1;
                        ALUResult <= eng_lo;
                        Zero      <= (eng_lo == '0);
                        Overflow  <= 1'b0;
                        Illegal   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_seq.sv
// Scoreboard bench for mips_alu_seq; DIVU checks follow MIPS_ALU_SEQ_DIV_EN.
// Expected results are queued at issue and popped when out_valid appears.
module tb_mips_alu_seq;

    localparam int W = 32;

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010;
    localparam logic [3:0] XOR_ = 4'b0011, MUL_ = 4'b0100, DIV_ = 4'b0101;
    localparam logic [3:0] SUB_ = 4'b0110, SLT_ = 4'b0111, SLL_ = 4'b1000;
    localparam logic [3:0] SRL_ = 4'b1001, SRA_ = 4'b1010, SLTU_ = 4'b1011;
    localparam logic [3:0] NOR_ = 4'b1100, MFHI_ = 4'b1101, MFLO_ = 4'b1110;
    localparam logic [3:0] BAD_ = 4'b1111;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         o;
        logic         i;
    } exp_t;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         o;
        logic         i;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   ctl = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] ALUResult;
    logic         Zero;
    logic         Overflow;
    logic         Illegal;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    mips_alu_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALUControl (ctl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [W-1:0] r, input logic o, input logic i);
        return {r, r == '0, o, i};
    endfunction

    function automatic vec_t mkv(input logic [3:0] op, input logic [W-1:0] a, b, r,
                                 input logic o, input logic i);
        return {op, a, b, r, o, i};
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, b,
                        output int c, output bit to);
        int n = 0;
        bit acc;
        in_valid = 1'b1;
        ctl = op;
        A = a;
        B = b;
        #1;
        acc = in_ready;
        c = cyc;
        while (!acc && n < 200) begin
            @(posedge clk); #1;
            n++;
            acc = in_ready;
            c = cyc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        to = !acc;
    endtask

    task automatic wait_out(output int c, output bit to, output bit rdy);
        int n = 0;
        rdy = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) rdy = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        c = cyc;
        to = !out_valid;
    endtask

    task automatic run(input logic [3:0] op, input logic [W-1:0] a, b,
                       output exp_t got, output int lat, output bit to, output bit rdy);
        int c0, c1;
        bit t0, t1;
        send(op, a, b, c0, t0);
        wait_out(c1, t1, rdy);
        got = {ALUResult, Zero, Overflow, Illegal};
        lat = c1 - c0;
        to = t0 | t1;
    endtask

    task automatic test_reset;
        exp_t got, e;
        int lat, c;
        bit to, rdy, seen;
        vec_t tv[4];
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_hs: got valid=%b ready=%b want 0 0", out_valid, in_ready);
        end
        checks++;
        if ({ALUResult, Zero, Overflow, Illegal} !== {{W{1'b0}}, 3'b100}) begin
            errors++;
            $display("FAIL reset_out: got %h z%b o%b i%b want 0 z1 o0 i0",
                     ALUResult, Zero, Overflow, Illegal);
        end
        reset = 1'b0;
        tv = '{mkv(MUL_, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 0, 0),
               mkv(MFHI_, 0, 0, 32'h1, 0, 0),
               mkv(MFHI_, 0, 0, 32'h0, 0, 0),
               mkv(MFLO_, 0, 0, 32'h0, 0, 0)};
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                send(MUL_, 32'h12345678, 32'h9, c, to);
                repeat (5) @(posedge clk);
                #1;
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                checks++;
                if (to || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid: got valid=%b ready=%b want 0 0",
                             out_valid, in_ready);
                end
                reset = 1'b0;
                seen = 1'b0;
                repeat (40) begin
                    @(posedge clk); #1;
                    if (out_valid) seen = 1'b1;
                end
                checks++;
                if (seen) begin
                    errors++;
                    $display("FAIL reset_abort: got out_valid=1 want 0");
                end
            end
            sb.push_back(mk(tv[k].r, tv[k].o, tv[k].i));
            run(tv[k].op, tv[k].a, tv[k].b, got, lat, to, rdy);
            e = sb.pop_front();
            checks++;
            if (to || got !== e) begin
                errors++;
                $display("FAIL reset_seq[%0d]: got %h z%b o%b i%b want %h z%b o%b i%b to=%b",
                         k, got.res, got.z, got.o, got.i, e.res, e.z, e.o, e.i, to);
            end
        end
    endtask

    task automatic test_arith;
        exp_t got, e;
        int lat;
        bit to, rdy;
        vec_t tv[11];
        tv = '{mkv(ADD_, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0),
               mkv(SUB_, 32'h5, 32'h5, 32'h0, 0, 0),
               mkv(SUB_, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0),
               mkv(ADD_, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0),
               mkv(SLT_, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0),
               mkv(SLTU_, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0),
               mkv(AND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0),
               mkv(OR_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0),
               mkv(XOR_, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0),
               mkv(NOR_, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0),
               mkv(BAD_, 32'h1234, 32'h5678, 32'h0, 0, 1)};
        for (int k = 0; k < 11; k++) begin
            sb.push_back(mk(tv[k].r, tv[k].o, tv[k].i));
            run(tv[k].op, tv[k].a, tv[k].b, got, lat, to, rdy);
            e = sb.pop_front();
            checks++;
            if (to || got !== e || lat != 1) begin
                errors++;
                $display("FAIL arith[%0d]: got %h z%b o%b i%b lat %0d want %h z%b o%b i%b lat 1",
                         k, got.res, got.z, got.o, got.i, lat, e.res, e.z, e.o, e.i);
            end
        end
    endtask

    task automatic test_shift;
        exp_t got, e;
        int lat;
        bit to, rdy;
        vec_t tv[5];
        tv = '{mkv(SRA_, 32'h80000000, 32'h4, 32'hF8000000, 0, 0),
               mkv(SLL_, 32'h1, 32'h21, 32'h2, 0, 0),
               mkv(SRL_, 32'h80000000, 32'h1F, 32'h1, 0, 0),
               mkv(SLL_, 32'h1, 32'h1F, 32'h80000000, 0, 0),
               mkv(SRA_, 32'h7FFFFFFF, 32'h1F, 32'h0, 0, 0)};
        for (int k = 0; k < 5; k++) begin
            sb.push_back(mk(tv[k].r, tv[k].o, tv[k].i));
            run(tv[k].op, tv[k].a, tv[k].b, got, lat, to, rdy);
            e = sb.pop_front();
            checks++;
            if (to || got !== e) begin
                errors++;
                $display("FAIL shift[%0d]: got %h z%b o%b i%b want %h z%b o%b i%b",
                         k, got.res, got.z, got.o, got.i, e.res, e.z, e.o, e.i);
            end
        end
    endtask

    task automatic test_multu;
        exp_t got, e;
        int lat;
        bit to, rdy;
        logic [2*W-1:0] p;
        logic [W-1:0] ra, rb;
        vec_t tv[5];
        ra = $urandom;
        rb = $urandom;
        p = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
        tv = '{mkv(MUL_, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 0, 0),
               mkv(MFHI_, 0, 0, 32'h1, 0, 0),
               mkv(MFLO_, 0, 0, 32'hFFFFFFFE, 0, 0),
               mkv(MUL_, ra, rb, p[W-1:0], 0, 0),
               mkv(MFHI_, 0, 0, p[2*W-1:W], 0, 0)};
        for (int k = 0; k < 5; k++) begin
            sb.push_back(mk(tv[k].r, tv[k].o, tv[k].i));
            run(tv[k].op, tv[k].a, tv[k].b, got, lat, to, rdy);
            e = sb.pop_front();
            checks++;
            if (to || got !== e) begin
                errors++;
                $display("FAIL multu[%0d]: got %h z%b o%b i%b want %h z%b o%b i%b",
                         k, got.res, got.z, got.o, got.i, e.res, e.z, e.o, e.i);
            end
            if (tv[k].op == MUL_) begin
                checks++;
                if (lat != W + 1 || rdy) begin
                    errors++;
                    $display("FAIL multu_lat[%0d]: got lat %0d ready_seen %b want lat %0d ready_seen 0",
                             k, lat, rdy, W + 1);
                end
            end
        end
    endtask

    task automatic test_divu;
        exp_t got, e;
        int lat;
        bit to, rdy;
`ifdef MIPS_ALU_SEQ_DIV_EN
        logic [W-1:0] ra, rb;
        vec_t tv[6];
        ra = $urandom;
        rb = W'($urandom_range(1, 1000));
        tv = '{mkv(DIV_, 32'd100, 32'd7, 32'd14, 0, 0),
               mkv(MFHI_, 0, 0, 32'd2, 0, 0),
               mkv(DIV_, 32'd9, 32'd0, 32'hFFFFFFFF, 0, 0),
               mkv(MFHI_, 0, 0, 32'd9, 0, 0),
               mkv(DIV_, ra, rb, ra / rb, 0, 0),
               mkv(MFHI_, 0, 0, ra % rb, 0, 0)};
        for (int k = 0; k < 6; k++) begin
`else
        vec_t tv[4];
        tv = '{mkv(MUL_, 32'd3, 32'd5, 32'd15, 0, 0),
               mkv(DIV_, 32'd100, 32'd7, 32'd0, 0, 1),
               mkv(MFLO_, 0, 0, 32'd15, 0, 0),
               mkv(MFHI_, 0, 0, 32'd0, 0, 0)};
        for (int k = 0; k < 4; k++) begin
`endif
            sb.push_back(mk(tv[k].r, tv[k].o, tv[k].i));
            run(tv[k].op, tv[k].a, tv[k].b, got, lat, to, rdy);
            e = sb.pop_front();
            checks++;
            if (to || got !== e) begin
                errors++;
                $display("FAIL divu[%0d]: got %h z%b o%b i%b want %h z%b o%b i%b",
                         k, got.res, got.z, got.o, got.i, e.res, e.z, e.o, e.i);
            end
            if (tv[k].op == DIV_) begin
                checks++;
`ifdef MIPS_ALU_SEQ_DIV_EN
                if (lat != W + 1 || rdy) begin
`else
                if (lat != 1) begin
`endif
                    errors++;
                    $display("FAIL divu_lat[%0d]: got lat %0d ready_seen %b", k, lat, rdy);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t got, e;
        vec_t tv[4];
        tv = '{mkv(ADD_, 32'd10, 32'd20, 32'd30, 0, 0),
               mkv(SUB_, 32'd10, 32'd20, 32'hFFFFFFF6, 0, 0),
               mkv(XOR_, 32'd3, 32'd5, 32'd6, 0, 0),
               mkv(SLL_, 32'd1, 32'd4, 32'd16, 0, 0)};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ctl = tv[k].op;
            A = tv[k].a;
            B = tv[k].b;
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready);
            end
            sb.push_back(mk(tv[k].r, tv[k].o, tv[k].i));
            @(posedge clk); #1;
            got = {ALUResult, Zero, Overflow, Illegal};
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || got !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: got v%b %h z%b o%b i%b want v1 %h z%b o%b i%b",
                         k, out_valid, got.res, got.z, got.o, got.i, e.res, e.z, e.o, e.i);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        exp_t got, e;
        int c;
        bit to;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        sb.push_back(mk(32'd3, 1'b0, 1'b0));
        send(ADD_, 32'd1, 32'd2, c, to);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (to || out_valid !== 1'b1 || ALUResult !== 32'd3 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got v%b %h ready %b want v1 00000003 ready 0",
                         k, out_valid, ALUResult, in_ready);
            end
            @(posedge clk); #1;
        end
        got = {ALUResult, Zero, Overflow, Illegal};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL held_val: got %h z%b o%b i%b want %h z%b o%b i%b",
                     got.res, got.z, got.o, got.i, e.res, e.z, e.o, e.i);
        end
        ctl = OR_;
        A = 32'd5;
        B = 32'd2;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pop_accept: got ready %b want 1", in_ready);
        end
        sb.push_back(mk(32'd7, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = {ALUResult, Zero, Overflow, Illegal};
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL pop_next: got v%b %h z%b o%b i%b want v1 %h z%b o%b i%b",
                     out_valid, got.res, got.z, got.o, got.i, e.res, e.z, e.o, e.i);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_multu();
        test_divu();
        test_back_to_back();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
